// File: rtl/timer_mc.sv
// Multi-channel timer: N_CH counters share one prescaler; each channel has free-run/periodic/one-shot
// modes, compare match pulse, sticky irq and a snapshot register. Optional TIMER_CAPTURE_EN adds cap_in.
module timer_mc #(
  parameter int N_CH    = 4,
  parameter int COUNT_W = 32,
  parameter int PRESC_W = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [PRESC_W-1:0]        presc_div,
  input  logic [N_CH-1:0]           ch_en,
  input  logic [2*N_CH-1:0]         ch_mode,
  input  logic [N_CH-1:0]           ch_clear,
  input  logic [N_CH*COUNT_W-1:0]   ch_cmp,
  input  logic [N_CH-1:0]           ch_sample,
  input  logic [N_CH-1:0]           ch_irq_clr,
`ifdef TIMER_CAPTURE_EN
  input  logic [N_CH-1:0]           cap_in,
`endif
  output logic [N_CH*COUNT_W-1:0]   ch_value,
  output logic [N_CH-1:0]           ch_match,
  output logic [N_CH-1:0]           ch_irq
);

  localparam logic [1:0] MODE_PERIODIC = 2'b01;
  localparam logic [1:0] MODE_ONESHOT  = 2'b10;

  logic [PRESC_W-1:0] presc_cnt;
  logic               any_en;
  logic               tick;
  logic [N_CH-1:0]    cap_evt;

  assign any_en = |ch_en;
  assign tick   = any_en && (presc_cnt == presc_div);

  // A presc_cnt already above a newly lowered presc_div simply runs on through the wrap to 0.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                presc_cnt <= '0;
    else if (!any_en || tick) presc_cnt <= '0;
    else                     presc_cnt <= presc_cnt + PRESC_W'(1);
  end

`ifdef TIMER_CAPTURE_EN
  logic [N_CH-1:0] cap_s1, cap_s2, cap_s3;

  // Two-flop synchroniser, then a registered rising-edge pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cap_s1  <= '0;
      cap_s2  <= '0;
      cap_s3  <= '0;
      cap_evt <= '0;
    end else begin
      cap_s1  <= cap_in;
      cap_s2  <= cap_s1;
      cap_s3  <= cap_s2;
      cap_evt <= cap_s2 & ~cap_s3;
    end
  end
`else
  assign cap_evt = '0;
`endif

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    logic [COUNT_W-1:0] cnt, cnt_nxt, cmp, value_q;
    logic [1:0]         mode;
    logic               halted, halted_nxt, match_evt, match_q, irq_q;

    assign cmp  = ch_cmp[g*COUNT_W +: COUNT_W];
    assign mode = ch_mode[2*g +: 2];

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
      cnt_nxt    = cnt;
      halted_nxt = halted;
      match_evt  = 1'b0;
      if (ch_clear[g]) begin
        cnt_nxt    = '0;
        halted_nxt = 1'b0;
      end else if (!ch_en[g]) begin
        halted_nxt = 1'b0;
      end else if (tick && !halted) begin
        if (cnt == cmp) begin
          match_evt = 1'b1;
          case (mode)
            MODE_PERIODIC: cnt_nxt    = '0;
            MODE_ONESHOT:  halted_nxt = 1'b1;
            default:       cnt_nxt    = cnt + COUNT_W'(1);
          endcase
        end else begin
          cnt_nxt = cnt + COUNT_W'(1);
        end
      end
    end

    // Snapshot takes the pre-update count; capture and sample load the same cnt, capture listed first.
    // NOTE: the snapshot register is reset like any other state because software reads it after reset.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        cnt     <= '0;
        halted  <= 1'b0;
        match_q <= 1'b0;
        irq_q   <= 1'b0;
        value_q <= '0;
      end else begin
        cnt     <= cnt_nxt;
        halted  <= halted_nxt;
        match_q <= match_evt;
        if (match_evt)          irq_q <= 1'b1;
        else if (ch_irq_clr[g]) irq_q <= 1'b0;
        if (cap_evt[g])         value_q <= cnt;
        else if (ch_sample[g])  value_q <= cnt;
      end
    end

    assign ch_value[g*COUNT_W +: COUNT_W] = value_q;
    assign ch_match[g]                    = match_q;
    assign ch_irq[g]                      = irq_q;
  end

endmodule

// File: tb/tb_timer_mc.sv
// Scoreboard bench for timer_mc (N_CH=4, COUNT_W=8): expected match cycles and snapshot values are
// queued by the stimulus and popped by a negedge monitor. Capture checks run with TIMER_CAPTURE_EN.
module tb_timer_mc;
  localparam int N  = 4;
  localparam int CW = 8;
  localparam int PW = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [PW-1:0]     presc_div;
  logic [N-1:0]      ch_en, ch_clear, ch_sample, ch_irq_clr, cap_in;
  logic [2*N-1:0]    ch_mode;
  logic [N*CW-1:0]   ch_cmp;
  logic [N*CW-1:0]   ch_value;
  logic [N-1:0]      ch_match, ch_irq;

  typedef struct {int ch; int val;} exp_t;
  exp_t match_q[$];
  exp_t val_q[$];

  int           n_checks = 0;
  int           n_err    = 0;
  int           cyc      = 0;
  logic [N-1:0] smp_d    = '0;

  timer_mc #(.N_CH(N), .COUNT_W(CW), .PRESC_W(PW)) dut (
    .clk        (clk),
    .rst        (rst),
    .presc_div  (presc_div),
    .ch_en      (ch_en),
    .ch_mode    (ch_mode),
    .ch_clear   (ch_clear),
    .ch_cmp     (ch_cmp),
    .ch_sample  (ch_sample),
    .ch_irq_clr (ch_irq_clr),
`ifdef TIMER_CAPTURE_EN
    .cap_in     (cap_in),
`endif
    .ch_value   (ch_value),
    .ch_match   (ch_match),
    .ch_irq     (ch_irq)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    smp_d <= ch_sample;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: a match pulse or a completed sample pops the next expectation.
  always @(negedge clk) begin
    exp_t e;
    for (int i = 0; i < N; i++) begin
      if (ch_match[i]) begin
        if (match_q.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL match_unexpected: ch %0d pulsed at cycle %0d, none expected", i, cyc);
        end else begin
          e = match_q.pop_front();
          check("match_ch", i, e.ch);
          check("match_cyc", cyc, e.val);
        end
      end
      if (smp_d[i]) begin
        if (val_q.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL value_unexpected: ch %0d sample with no expectation", i);
        end else begin
          e = val_q.pop_front();
          check("value_ch", i, e.ch);
          check("value", ch_value[i*CW +: CW], e.val);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ch_en      = '0;
    ch_sample  = '0;
    ch_irq_clr = '0;
    ch_clear   = '1;
    step();
    step();
    ch_clear   = '0;
    step();
  endtask

  task automatic set_ch(input int ch, input logic [1:0] m, input logic [CW-1:0] c);
    ch_mode[2*ch +: 2]  = m;
    ch_cmp[ch*CW +: CW] = c;
  endtask

  task automatic exp_match(input int ch, input int c);
    match_q.push_back('{ch, c});
  endtask

  task automatic exp_value(input int ch, input int v);
    val_q.push_back('{ch, v});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int k;
    rst = 1'b0; presc_div = '0; ch_en = '0; ch_clear = '0; ch_sample = '0;
    ch_irq_clr = '0; cap_in = '0; ch_mode = '0; ch_cmp = '1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_value", ch_value, 0);
    check("rst_match", ch_match, 0);
    check("rst_irq", ch_irq, 0);
    rst = 1'b1;
    idle();

    // Prescaler: div 3 -> one tick per 4 clocks, 40 clocks -> 10
    presc_div = 16'd3;
    for (int i = 0; i < N; i++) set_ch(i, 2'b00, 8'd255);
    ch_en = 4'b0001;
    repeat (40) step();
    ch_sample = 4'b1111;
    exp_value(0, 10); exp_value(1, 0); exp_value(2, 0); exp_value(3, 0);
    step();
    ch_sample = '0;
    idle();

    // Periodic cmp=5: match every 6 clocks, counter 0..5
    presc_div = '0;
    set_ch(1, 2'b01, 8'd5);
    ch_en = 4'b0010;
    k = cyc;
    exp_match(1, k + 6); exp_match(1, k + 12); exp_match(1, k + 18);
    for (int j = 1; j <= 18; j++) begin
      step();
      if (j == 5) check("periodic_irq_before", ch_irq[1], 1'b0);
      if (j == 6) check("periodic_irq_set", ch_irq[1], 1'b1);
      if (j == 8) begin ch_sample = 4'b0010; exp_value(1, 2); end
      if (j == 9) ch_sample = '0;
    end
    idle();

    // One-shot cmp=7: single match, frozen at 7, clear restarts, second match 8 clocks later
    set_ch(2, 2'b10, 8'd7);
    ch_en = 4'b0100;
    k = cyc;
    exp_match(2, k + 8); exp_match(2, k + 29);
    for (int j = 1; j <= 35; j++) begin
      step();
      if (j == 15) begin ch_sample = 4'b0100; exp_value(2, 7); end
      if (j == 16) ch_sample = '0;
      if (j == 20) ch_clear = 4'b0100;
      if (j == 21) ch_clear = '0;
      if (j == 24) begin ch_sample = 4'b0100; exp_value(2, 3); end
      if (j == 25) ch_sample = '0;
    end
    idle();

    // Irq: clear all, then set beats clear in the same cycle, then clear alone
    ch_irq_clr = '1;
    step();
    check("irq_clear_all", ch_irq, 4'b0000);
    ch_irq_clr = '0;
    set_ch(3, 2'b01, 8'd2);
    ch_en = 4'b1000;
    k = cyc;
    exp_match(3, k + 3);
    step();
    step();
    check("irq_before_match", ch_irq[3], 1'b0);
    ch_irq_clr = 4'b1000;
    step();
    check("irq_set_wins", ch_irq[3], 1'b1);
    ch_irq_clr = '0;
    ch_en = '0;
    step();
    ch_irq_clr = 4'b1000;
    step();
    check("irq_clear_alone", ch_irq[3], 1'b0);
    ch_irq_clr = '0;
    idle();

    // Wrap 255 -> 0 with a match, then async reset mid-count
    set_ch(0, 2'b00, 8'd255);
    ch_en = 4'b0001;
    k = cyc;
    exp_match(0, k + 256);
    for (int j = 1; j <= 260; j++) begin
      step();
      if (j == 255) begin ch_sample = 4'b0001; exp_value(0, 255); end
      if (j == 256) exp_value(0, 0);
      if (j == 257) ch_sample = '0;
      if (j == 258) begin ch_sample = 4'b0001; exp_value(0, 2); end
      if (j == 259) ch_sample = '0;
    end
    check("irq_pre_reset", ch_irq, 4'b0001);
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_value", ch_value, 0);
    check("async_rst_match", ch_match, 0);
    check("async_rst_irq", ch_irq, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (3) step();
    ch_sample = 4'b0001;
    exp_value(0, 3);
    step();
    ch_sample = '0;
    idle();

`ifdef TIMER_CAPTURE_EN
    // Capture: rise at cnt=20 -> value 23; capture together with sample -> 33
    set_ch(1, 2'b00, 8'd255);
    ch_en = 4'b0010;
    for (int j = 1; j <= 36; j++) begin
      step();
      if (j == 20) cap_in = 4'b0010;
      if (j == 25) check("capture_value", ch_value[1*CW +: CW], 23);
      if (j == 26) cap_in = '0;
      if (j == 30) cap_in = 4'b0010;
      if (j == 33) begin ch_sample = 4'b0010; exp_value(1, 33); end
      if (j == 34) ch_sample = '0;
    end
    cap_in = '0;
    idle();
`endif

    step();
    step();
    check("match_q_drained", match_q.size(), 0);
    check("value_q_drained", val_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
